// File: rtl/tictac_ctrl_pkg.sv
// rtl/tictac_ctrl_pkg.sv - shared cell codes, FSM encoding and winning-line table
package tictac_ctrl_pkg;

    localparam int BOARD_W = 18;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] PA    = 2'd1;
    localparam logic [1:0] PB    = 2'd2;

    localparam logic [3:0] MAX_MOVES = 4'd9;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    // Cell index triples for 3 rows, 3 columns and 2 diagonals
    localparam logic [3:0] LINE_TBL [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Two-bit code of cell idx within a packed board
    function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] b, input logic [3:0] idx);
        return b[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/tictac_ctrl_if.sv
// rtl/tictac_ctrl_if.sv - keypad/command inputs and board status outputs of the game controller
interface tictac_ctrl_if;

    logic                                 key_valid;
    logic [3:0]                           key_code;
    logic                                 new_game;
    logic [tictac_ctrl_pkg::BOARD_W-1:0]  board;
    logic [1:0]                           turn;
    logic                                 game_over;
    logic [1:0]                           winner;
    logic                                 illegal;

    modport master (
        output key_valid, key_code, new_game,
        input  board, turn, game_over, winner, illegal
    );

    modport slave (
        input  key_valid, key_code, new_game,
        output board, turn, game_over, winner, illegal
    );

endinterface

// File: rtl/tictac_win.sv
// rtl/tictac_win.sv - combinational detector for three equal non-empty cells on any line
module tictac_win
    import tictac_ctrl_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    output logic               win,
    output logic [1:0]         code
);

    logic [1:0] c0, c1, c2;

    // Scan the line table; the first complete line found reports its owner
    always_comb begin
        win  = 1'b0;
        code = EMPTY;
        c0   = EMPTY;
        c1   = EMPTY;
        c2   = EMPTY;
        for (int i = 0; i < 8; i++) begin
            c0 = cell_at(board, LINE_TBL[i][0]);
            c1 = cell_at(board, LINE_TBL[i][1]);
            c2 = cell_at(board, LINE_TBL[i][2]);
            if (!win && (c0 != EMPTY) && (c0 == c1) && (c1 == c2)) begin
                win  = 1'b1;
                code = c0;
            end
        end
    end

endmodule

// File: rtl/tictac_ctrl.sv
// rtl/tictac_ctrl.sv - tic-tac-toe game controller: move entry, win/draw check, turn keeping
module tictac_ctrl
    import tictac_ctrl_pkg::*;
#(
    parameter int FIRST_PLAYER = 1
) (
    input  logic         freq,
    input  logic         rst,
    tictac_ctrl_if.slave bus
);

    localparam logic [1:0] FIRST_CODE = 2'(FIRST_PLAYER);

    state_t             state_q, state_d;
    logic [BOARD_W-1:0] board_q, board_d;
    logic [1:0]         turn_q, turn_d;
    logic [1:0]         winner_q, winner_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               over_q, over_d;
    logic               illegal_q, illegal_d;
    logic               key_prev_q;
    logic               armed_q;

    logic               key_edge;
    logic               code_ok;
    logic               cell_free;
    logic [3:0]         cell_idx;
    logic               line_win;
    logic [1:0]         line_code;

    tictac_win u_win (
        .board (board_q),
        .win   (line_win),
        .code  (line_code)
    );

    // armed stays low until the key has been seen released after reset,
    // so a key held across reset release never counts as a press
    assign key_edge  = bus.key_valid & ~key_prev_q & armed_q;
    assign code_ok   = (bus.key_code >= 4'd1) && (bus.key_code <= 4'd9);
    assign cell_idx  = code_ok ? (bus.key_code - 4'd1) : 4'd0;
    assign cell_free = (cell_at(board_q, cell_idx) == EMPTY);

    // Keypad edge detector
    always_ff @(posedge freq or negedge rst) begin
        if (!rst) begin
            key_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            key_prev_q <= bus.key_valid;
            armed_q    <= armed_q | ~bus.key_valid;
        end
    end

    // Game state register; every output comes straight from here
    always_ff @(posedge freq or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_PLAY;
            board_q   <= '0;
            turn_q    <= FIRST_CODE;
            winner_q  <= EMPTY;
            cnt_q     <= '0;
            over_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            turn_q    <= turn_d;
            winner_q  <= winner_d;
            cnt_q     <= cnt_d;
            over_q    <= over_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state: new_game first, then move entry in PLAY, outcome in CHECK
    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        turn_d    = turn_q;
        winner_d  = winner_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        if (bus.new_game) begin
            state_d  = ST_PLAY;
            board_d  = '0;
            turn_d   = FIRST_CODE;
            winner_d = EMPTY;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (key_edge) begin
                        if (code_ok && cell_free) begin
                            board_d[{cell_idx, 1'b0} +: 2] = turn_q;
                            if (cnt_q != MAX_MOVES) begin
                                cnt_d = cnt_q + 4'd1;
                            end
                            state_d = ST_CHECK;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (line_win) begin
                        state_d  = ST_OVER;
                        winner_d = line_code;
                    end else if (cnt_q == MAX_MOVES) begin
                        state_d  = ST_OVER;
                        winner_d = EMPTY;
                    end else begin
                        turn_d  = (turn_q == PA) ? PB : PA;
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                end
            endcase
        end
        over_d = (state_d == ST_OVER);
    end

    assign bus.board     = board_q;
    assign bus.turn      = turn_q;
    assign bus.game_over = over_q;
    assign bus.winner    = winner_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_tictac_ctrl.sv
// tb/tb_tictac_ctrl.sv - vector table, reset sequences and randomized play against a game model
module tb_tictac_ctrl;

    logic freq;
    logic rst;

    tictac_ctrl_if bus ();

    tictac_ctrl #(.FIRST_PLAYER(1)) dut (
        .freq (freq),
        .rst  (rst),
        .bus  (bus.slave)
    );

    initial begin
        freq = 1'b0;
        forever #5 freq = ~freq;
    end

    int checks = 0;
    int errors = 0;

    // op: 0 key press, 1 new_game alone, 2 new_game together with a key edge
    typedef struct {
        int         op;
        logic [3:0] code;
        logic       ill;
        logic [17:0] brd;
        logic [1:0] trn;
        logic       ovr;
        logic [1:0] win;
    } vec_t;

    vec_t vt[$];

    int m_cell[9];
    int m_turn, m_cnt, m_over, m_win;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge freq);
        #1;
    endtask

    task automatic add(input int op, input logic [3:0] code, input logic ill, input logic [17:0] brd,
                       input logic [1:0] trn, input logic ovr, input logic [1:0] win);
        vec_t v;
        v.op = op; v.code = code; v.ill = ill; v.brd = brd; v.trn = trn; v.ovr = ovr; v.win = win;
        vt.push_back(v);
    endtask

    task automatic run_vec(input int op, input logic [3:0] code, input int hold, input logic eill,
                           input logic [17:0] ebrd, input logic [1:0] etrn, input logic eovr,
                           input logic [1:0] ewin);
        bus.key_code = code;
        if (op == 1) begin
            bus.new_game = 1'b1;
            step();
            bus.new_game = 1'b0;
        end else begin
            bus.new_game  = (op == 2);
            bus.key_valid = 1'b1;
            step();
            bus.new_game = 1'b0;
            check("illegal_pulse", 32'(bus.illegal), 32'(eill));
            for (int i = 1; i < hold; i++) step();
            bus.key_valid = 1'b0;
        end
        step();
        check("board", 32'(bus.board), 32'(ebrd));
        check("turn", 32'(bus.turn), 32'(etrn));
        check("game_over", 32'(bus.game_over), 32'(eovr));
        check("winner", 32'(bus.winner), 32'(ewin));
        check("illegal_after", 32'(bus.illegal), 32'd0);
    endtask

    function automatic int m_three(input int a, input int b, input int c);
        return (m_cell[a] != 0 && m_cell[a] == m_cell[b] && m_cell[b] == m_cell[c]) ? m_cell[a] : 0;
    endfunction

    function automatic int m_line();
        int w;
        w = 0;
        for (int r = 0; r < 3; r++) begin
            if (w == 0) w = m_three(3*r, 3*r + 1, 3*r + 2);
            if (w == 0) w = m_three(r, r + 3, r + 6);
        end
        if (w == 0) w = m_three(0, 4, 8);
        if (w == 0) w = m_three(2, 4, 6);
        return w;
    endfunction

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = '0;
        for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(m_cell[k]);
        return b;
    endfunction

    task automatic model_apply(input int op, input int code, output logic ill);
        int w;
        ill = 1'b0;
        if (op != 0) begin
            for (int k = 0; k < 9; k++) m_cell[k] = 0;
            m_turn = 1; m_cnt = 0; m_over = 0; m_win = 0;
        end else if (m_over != 0) begin
            ill = 1'b0;
        end else if (code < 1 || code > 9 || m_cell[code - 1] != 0) begin
            ill = 1'b1;
        end else begin
            m_cell[code - 1] = m_turn;
            m_cnt++;
            w = m_line();
            if (w != 0) begin
                m_over = 1; m_win = w;
            end else if (m_cnt == 9) begin
                m_over = 1; m_win = 0;
            end else begin
                m_turn = 3 - m_turn;
            end
        end
    endtask

    initial begin
        logic ill;
        int op, code, hold;

        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.new_game  = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_board", 32'(bus.board), 32'd0);
        check("rst_turn", 32'(bus.turn), 32'd1);
        check("rst_over", 32'(bus.game_over), 32'd0);
        check("rst_winner", 32'(bus.winner), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);

        // key held across reset release must not become a move
        bus.key_code  = 4'd1;
        bus.key_valid = 1'b1;
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("held_no_illegal", 32'(bus.illegal), 32'd0);
        end
        check("held_board", 32'(bus.board), 32'd0);
        check("held_turn", 32'(bus.turn), 32'd1);
        bus.key_valid = 1'b0;
        step();
        check("released_board", 32'(bus.board), 32'd0);
        bus.key_code  = 4'd2;
        bus.key_valid = 1'b1;
        step();
        check("repress_board", 32'(bus.board), 32'h4);
        // now in CHECK: reset must clear outputs without a clock edge
        #1 rst = 1'b0;
        #1;
        check("async_board", 32'(bus.board), 32'd0);
        check("async_turn", 32'(bus.turn), 32'd1);
        check("async_over", 32'(bus.game_over), 32'd0);
        check("async_winner", 32'(bus.winner), 32'd0);
        check("async_illegal", 32'(bus.illegal), 32'd0);
        bus.key_valid = 1'b0;
        step();
        rst = 1'b1;
        step();

        // win for player 1 on the top row
        add(1, 4'd0,  1'b0, 18'h00000, 2'd1, 1'b0, 2'd0);
        add(0, 4'd1,  1'b0, 18'h00001, 2'd2, 1'b0, 2'd0);
        add(0, 4'd4,  1'b0, 18'h00081, 2'd1, 1'b0, 2'd0);
        add(0, 4'd2,  1'b0, 18'h00085, 2'd2, 1'b0, 2'd0);
        add(0, 4'd5,  1'b0, 18'h00285, 2'd1, 1'b0, 2'd0);
        add(0, 4'd3,  1'b0, 18'h00295, 2'd1, 1'b1, 2'd1);
        // keys ignored in OVER, then new_game beats a simultaneous key edge
        add(0, 4'd7,  1'b0, 18'h00295, 2'd1, 1'b1, 2'd1);
        add(2, 4'd7,  1'b0, 18'h00000, 2'd1, 1'b0, 2'd0);
        // occupied cell and out-of-range codes
        add(0, 4'd5,  1'b0, 18'h00100, 2'd2, 1'b0, 2'd0);
        add(0, 4'd5,  1'b1, 18'h00100, 2'd2, 1'b0, 2'd0);
        add(0, 4'd0,  1'b1, 18'h00100, 2'd2, 1'b0, 2'd0);
        add(0, 4'd12, 1'b1, 18'h00100, 2'd2, 1'b0, 2'd0);
        // draw with rejected moves interleaved; counter must reach exactly 9
        add(1, 4'd0,  1'b0, 18'h00000, 2'd1, 1'b0, 2'd0);
        add(0, 4'd1,  1'b0, 18'h00001, 2'd2, 1'b0, 2'd0);
        add(0, 4'd2,  1'b0, 18'h00009, 2'd1, 1'b0, 2'd0);
        add(0, 4'd3,  1'b0, 18'h00019, 2'd2, 1'b0, 2'd0);
        add(0, 4'd5,  1'b0, 18'h00219, 2'd1, 1'b0, 2'd0);
        add(0, 4'd4,  1'b0, 18'h00259, 2'd2, 1'b0, 2'd0);
        add(0, 4'd0,  1'b1, 18'h00259, 2'd2, 1'b0, 2'd0);
        add(0, 4'd15, 1'b1, 18'h00259, 2'd2, 1'b0, 2'd0);
        add(0, 4'd4,  1'b1, 18'h00259, 2'd2, 1'b0, 2'd0);
        add(0, 4'd6,  1'b0, 18'h00A59, 2'd1, 1'b0, 2'd0);
        add(0, 4'd8,  1'b0, 18'h04A59, 2'd2, 1'b0, 2'd0);
        add(0, 4'd7,  1'b0, 18'h06A59, 2'd1, 1'b0, 2'd0);
        add(0, 4'd9,  1'b0, 18'h16A59, 2'd1, 1'b1, 2'd0);

        foreach (vt[i]) begin
            run_vec(vt[i].op, vt[i].code, 1, vt[i].ill, vt[i].brd, vt[i].trn, vt[i].ovr, vt[i].win);
        end

        // randomized play against the game model
        model_apply(1, 0, ill);
        run_vec(1, 4'd0, 1, 1'b0, m_board(), 2'(m_turn), m_over[0], 2'(m_win));
        for (int n = 0; n < 400; n++) begin
            op = 0;
            if ((m_over != 0 && $urandom_range(0, 2) == 0) || $urandom_range(0, 24) == 0) begin
                op = ($urandom_range(0, 1) == 0) ? 1 : 2;
            end
            code = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 9));
            hold = $urandom_range(1, 3);
            model_apply(op, code, ill);
            run_vec(op, 4'(code), hold, ill, m_board(), 2'(m_turn), m_over[0], 2'(m_win));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tictac_ctrl.md
TICTAC_CTRL -- requirements
Module: tictac_ctrl

Interface
REQ-001 Parameter FIRST_PLAYER, default 1; player code that moves first after reset or new game (1 or 2).
REQ-002 freq  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 key_valid  input  1  level from the keypad scanner; high while a key is held.
REQ-005 key_code  input  4  cell index 1..9, row-major, top-left = 1; other values are invalid.
REQ-006 new_game  input  1  synchronous restart request, level-sensitive, one clock minimum.
REQ-007 board  output  18  cell k (0..8) occupies board[2k+1:2k]; code 0 empty, 1 player A, 2 player B, 3 never driven.
REQ-008 turn  output  2  player code (1 or 2) to move next.
REQ-009 game_over  output  1  high in OVER state.
REQ-010 winner  output  2  0 no winner or draw, 1 or 2 winning player; valid while game_over.
REQ-011 illegal  output  1  one-clock pulse on a rejected move.

Function
REQ-012 The key is accepted on the rising edge of key_valid only (registered previous value); a held key is one move.
REQ-013 FSM states: PLAY, CHECK, OVER; encoding is in the package.
REQ-014 In PLAY, an accepted key with valid code on an empty cell writes turn into cell key_code-1 on that edge; state goes to CHECK.
REQ-015 In PLAY, an accepted key with invalid code or occupied cell leaves board unchanged, pulses illegal the next cycle, and stays in PLAY.
REQ-016 The move counter is 4 bits, counts 0..9, and increments once per written cell; it never wraps.
REQ-017 CHECK lasts exactly one cycle and evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) on the updated board.
REQ-018 CHECK outcomes: a line of three equal non-zero codes goes to OVER with winner set to that code; otherwise move count 9 goes to OVER with winner 0; otherwise turn toggles 1<->2 and the FSM returns to PLAY.
REQ-019 Latency is 2 clocks from the accepted key edge to updated turn or game_over.
REQ-020 In CHECK and OVER, key edges are ignored; illegal is not pulsed.
REQ-021 new_game in any state, on the next edge: board cleared, counter 0, turn FIRST_PLAYER, winner 0, state PLAY.
REQ-022 new_game has priority over a key edge in the same cycle; that key is discarded.
REQ-023 All outputs are registered; board is stable between writes, for direct use by the dot-matrix display.

Reset
REQ-024 When rst is low, asynchronously: board 0, turn FIRST_PLAYER, game_over 0, winner 0, illegal 0, counter 0, edge-detect register 0, state PLAY.
REQ-025 Reset mid-game discards the game; no partial move survives.
REQ-026 After release, a key already held does not count as a move until it is released and pressed again.

Structure
REQ-027 Shared package holds: cell codes (EMPTY, PA, PB), FSM state encoding, the 8-entry line table of cell index triples, and the board width of 18.
REQ-028 Sub-module tictac_win: combinational; input board[17:0]; outputs win (1 bit) and code (2 bits); instantiated once.

Verification
REQ-029 Reset, then keys 1,4,2,5,3 -> board cells 0,1,2 = 1 and cells 3,4 = 2; game_over = 1 and winner = 1 two clocks after the fifth key; turn stays 1.
REQ-030 Key 5, then key 5 again -> second press gives a one-cycle illegal pulse, board unchanged, turn stays 2.
REQ-031 key_code 0 and 12 in PLAY -> illegal pulse each time; counter and board unchanged.
REQ-032 Keys 1,2,3,5,4,6,8,7,9 -> no winning line; game_over = 1, winner = 0, counter 9.
REQ-033 In OVER, key 7 then new_game coinciding with a key edge -> board 0, turn FIRST_PLAYER, state PLAY; the key is not written.
REQ-034 Hold key_valid high across rst release, then assert rst low during CHECK -> no move from the held key; all outputs at reset values immediately, without waiting for a clock edge.
